// File: rtl/midi_tx_arbiter_if.sv
// Request/UART bus for midi_tx_arbiter.
// slave  : the arbiter side (consumes requests, drives the UART strobe/data).
// master : the requester/UART side.
interface midi_tx_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*24-1:0] req_msg;
  logic [NREQ*2-1:0]  req_len;
  logic [NREQ-1:0]    req_ack;
  logic               midi_send_byte;
  logic [7:0]         midi_out_data;
  logic               midi_out_ready;

  modport master (
    output req_valid, req_msg, req_len, midi_out_ready,
    input  req_ack, midi_send_byte, midi_out_data
  );

  modport slave (
    input  req_valid, req_msg, req_len, midi_out_ready,
    output req_ack, midi_send_byte, midi_out_data
  );
endinterface

// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter that serialises up to 3-byte MIDI messages from NREQ
// requesters onto a byte-strobe UART, with a per-phase handshake timeout.
// Optional feature: define RUNNING_STATUS_EN to omit a repeated channel
// status byte (0x80-0xEF) when it equals the last transmitted status.
module midi_tx_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned TO_CYCLES = 4095
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  midi_tx_arbiter_if.slave   bus,
  input  logic               clr_err,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic               tx_timeout
);

  localparam int unsigned CW = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ARB, SEND, WAIT_LOW, WAIT_HIGH, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      rdy_sync_q, rdy_sync_d;
  logic            rdy_s;
  logic [23:0]     msg_q, msg_d;
  logic [1:0]      len_q, len_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            send_q, send_d;
  logic [7:0]      data_q, data_d;
  logic            to_q, to_d;
`ifdef RUNNING_STATUS_EN
  logic [7:0]      rs_q, rs_d;
`endif

  logic            found;
  logic [1:0]      sel;
  logic [23:0]     sel_msg;
  logic [1:0]      sel_len;
  logic            skip_st;
  logic [1:0]      nidx;
  logic            timeout_hit;
  logic [NREQ-1:0] ack_vec;

  // Two-flop synchroniser for the UART idle flag (idle after reset).
  always_comb rdy_sync_d = {rdy_sync_q[0], bus.midi_out_ready};
  assign rdy_s = rdy_sync_q[1];

  // Round-robin search starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req_valid[(32'(rr_q) + i) % NREQ]) begin
        found = 1'b1;
        sel   = 2'((32'(rr_q) + i) % NREQ);
      end
    end
  end

  assign sel_msg = bus.req_msg[32'(sel)*24 +: 24];
  assign sel_len = bus.req_len[32'(sel)*2 +: 2];
  assign nidx    = idx_q + 2'd1;

  // Running-status match on the candidate message's status byte.
  always_comb begin
`ifdef RUNNING_STATUS_EN
    skip_st = (sel_msg[7:0] >= 8'h80) && (sel_msg[7:0] <= 8'hEF) &&
              (sel_msg[7:0] == rs_q);
`else
    skip_st = 1'b0;
`endif
  end

  // Next-state and datapath updates for the message sequencer.
  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    len_d       = len_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    send_d      = 1'b0;
    data_d      = data_q;
    to_d        = to_q;
    timeout_hit = 1'b0;
`ifdef RUNNING_STATUS_EN
    rs_d        = rs_q;
`endif
    if (clr_err) to_d = 1'b0;

    case (state_q)
      IDLE: if (|bus.req_valid) state_d = ARB;
      ARB: begin
        if (!found) begin
          state_d = IDLE;
        end else begin
          msg_d   = sel_msg;
          len_d   = sel_len;
          grant_d = sel;
          rr_d    = 2'((32'(sel) + 32'd1) % NREQ);
          idx_d   = {1'b0, skip_st};
          // Zero length, or a skipped status with nothing after it.
          if ({1'b0, skip_st} >= sel_len) begin
            state_d = DONE;
          end else begin
            data_d  = sel_msg[{skip_st, 3'b000} +: 8];
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (rdy_s) begin
          send_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_LOW;
`ifdef RUNNING_STATUS_EN
          if (idx_q == 2'd0) begin
            if (msg_q[7:0] >= 8'h80 && msg_q[7:0] <= 8'hEF) rs_d = msg_q[7:0];
            else if (msg_q[7:0] >= 8'hF0 && msg_q[7:0] <= 8'hF7) rs_d = '0;
          end
`endif
        end
      end
      WAIT_LOW: begin
        if (!rdy_s) begin
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end else if (cnt_q == CW'(TO_CYCLES)) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rdy_s) begin
          if ({1'b0, idx_q} + 3'd1 < {1'b0, len_q}) begin
            idx_d   = nidx;
            data_d  = msg_q[{nidx, 3'b000} +: 8];
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end else if (cnt_q == CW'(TO_CYCLES)) begin
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A timeout set wins over a same-cycle clr_err.
    if (timeout_hit) begin
      to_d    = 1'b1;
      state_d = DONE;
`ifdef RUNNING_STATUS_EN
      rs_d    = '0;
`endif
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= IDLE;
      rdy_sync_q <= '1;
      msg_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      grant_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      send_q     <= 1'b0;
      data_q     <= '0;
      to_q       <= 1'b0;
`ifdef RUNNING_STATUS_EN
      rs_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_sync_q <= rdy_sync_d;
      msg_q      <= msg_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      send_q     <= send_d;
      data_q     <= data_d;
      to_q       <= to_d;
`ifdef RUNNING_STATUS_EN
      rs_q       <= rs_d;
`endif
    end
  end

  // One-hot acknowledge for the granted requester while in DONE.
  always_comb begin
    ack_vec = '0;
    if (state_q == DONE) ack_vec[grant_q] = 1'b1;
  end

  assign bus.req_ack        = ack_vec;
  assign bus.midi_send_byte = send_q;
  assign bus.midi_out_data  = data_q;
  assign busy               = (state_q != IDLE);
  assign grant_id           = grant_q;
  assign tx_timeout         = to_q;

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Self-checking bench for midi_tx_arbiter: a message-level model builds the
// expected strobe/ack event stream; a per-cycle compare checks the DUT.
module tb_midi_tx_arbiter;
  localparam int unsigned TO = 4095;
`ifdef RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  logic       reg_clk     = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       clr_err     = 1'b0;
  logic       busy;
  logic [1:0] grant_id;
  logic       tx_timeout;

  midi_tx_arbiter_if #(.NREQ(3)) ifc();

  midi_tx_arbiter #(.NREQ(3), .TO_CYCLES(TO)) dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .bus         (ifc.slave),
    .clr_err     (clr_err),
    .busy        (busy),
    .grant_id    (grant_id),
    .tx_timeout  (tx_timeout)
  );

  always #5 reg_clk = ~reg_clk;

  // UART model: drops ready for uart_low cycles after each strobe.
  logic uart_rdy   = 1'b1;
  bit   uart_stuck = 1'b0;
  int   uart_low   = 20;
  int   low_left   = 0;
  assign ifc.midi_out_ready = uart_rdy;

  always @(posedge reg_clk) begin
    if (ifc.midi_send_byte === 1'b1 && !uart_stuck) begin
      uart_rdy <= 1'b0;
      low_left <= uart_low;
    end else if (low_left > 1) begin
      low_left <= low_left - 1;
    end else if (low_left == 1) begin
      low_left <= 0;
      uart_rdy <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int sent_log[$];
  int ack_log[$];
  int want[$];
  int m_ptr = 0;
  int m_rs = 0;
  bit m_stuck = 1'b0;
  logic [7:0] m_st[3], m_d1[3], m_d2[3];
  int m_len[3];
  int cyc_n = 0, strobe_cyc = 0, ack_cyc = 0, busy_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Per-cycle comparison against the expected event stream.
  task automatic compare();
    int e;
    logic [2:0] ea;
    if (ifc.midi_send_byte === 1'b1) begin
      sent_log.push_back(int'(ifc.midi_out_data));
      strobe_cyc = cyc_n;
      e = (exp_q.size() > 0) ? exp_q[0] : -1;
      chk("strobe_byte", {24'd0, ifc.midi_out_data}, 32'(e));
      chk("busy_on_strobe", 32'(busy), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (ifc.req_ack !== 3'b000) begin
      ack_log.push_back(int'(grant_id));
      ack_cyc = cyc_n;
      e  = (exp_q.size() > 0) ? exp_q[0] : -1;
      ea = (e >= 256) ? 3'(1 << (e - 256)) : 3'b000;
      chk("ack_vector", 32'(ifc.req_ack), 32'(ea));
      if (e >= 256) chk("grant_on_ack", 32'(grant_id), 32'(e - 256));
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (busy === 1'b1) busy_cyc++;
  endtask

  task automatic cyc();
    @(negedge reg_clk);
    cyc_n++;
    compare();
  endtask

  task automatic set_msg(input int i, input logic [7:0] st, input logic [7:0] d1,
                         input logic [7:0] d2, input int len);
    ifc.req_msg[i*24 +: 24] = {d2, d1, st};
    ifc.req_len[i*2 +: 2]   = 2'(len);
    m_st[i] = st; m_d1[i] = d1; m_d2[i] = d2; m_len[i] = len;
  endtask

  // Message-level model: list the bytes a message puts on the wire.
  task automatic model_msg(input int g);
    int b[3];
    int first;
    b[0] = int'(m_st[g]); b[1] = int'(m_d1[g]); b[2] = int'(m_d2[g]);
    first = (RS_EN && b[0] >= 'h80 && b[0] <= 'hEF && b[0] == m_rs) ? 1 : 0;
    for (int k = first; k < m_len[g]; k++) begin
      exp_q.push_back(b[k]);
      if (k == 0) begin
        if (b[0] >= 'h80 && b[0] <= 'hEF) m_rs = b[0];
        else if (b[0] >= 'hF0 && b[0] <= 'hF7) m_rs = 0;
      end
      if (m_stuck) begin
        m_rs = 0;
        break;
      end
    end
    exp_q.push_back(256 + g);
  endtask

  task automatic model_batch(input logic [2:0] mask);
    logic [2:0] pend;
    int g;
    pend = mask;
    while (pend != 3'b000) begin
      g = -1;
      for (int i = 0; i < 3; i++) begin
        if (g < 0 && pend[(m_ptr + i) % 3]) g = (m_ptr + i) % 3;
      end
      m_ptr = (g + 1) % 3;
      pend[g] = 1'b0;
      model_msg(g);
    end
  endtask

  task automatic start_batch(input logic [2:0] mask);
    ifc.req_valid = ifc.req_valid | mask;
    model_batch(mask);
  endtask

  task automatic wait_batch(input logic [2:0] mask, input int budget);
    logic [2:0] pend;
    int n;
    pend = mask;
    n = 0;
    while (pend != 3'b000 && n < budget) begin
      cyc();
      n++;
      for (int b = 0; b < 3; b++) begin
        if (pend[b] && ifc.req_ack[b] === 1'b1) begin
          pend[b] = 1'b0;
          ifc.req_valid[b] = 1'b0;
        end
      end
    end
    if (pend != 3'b000) chk("batch_completed_in_budget", 32'(pend), 32'd0);
  endtask

  task automatic check_log(input string name, input bit acks, input int from);
    int src[$];
    int v;
    src = acks ? ack_log : sent_log;
    chk({name, "_count"}, 32'(src.size() - from), 32'(want.size()));
    for (int k = 0; k < want.size(); k++) begin
      v = (from + k < src.size()) ? src[from + k] : -1;
      chk(name, 32'(v), 32'(want[k]));
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_send_byte"}, 32'(ifc.midi_send_byte), 32'd0);
    chk({tag, "_out_data"},  32'(ifc.midi_out_data),  32'd0);
    chk({tag, "_req_ack"},   32'(ifc.req_ack),        32'd0);
    chk({tag, "_busy"},      32'(busy),               32'd0);
    chk({tag, "_grant_id"},  32'(grant_id),           32'd0);
    chk({tag, "_tx_timeout"},32'(tx_timeout),         32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0, k;
    ifc.req_valid = '0;
    ifc.req_msg   = '0;
    ifc.req_len   = '0;
    repeat (3) cyc();
    reset_checks("por");
    reset_reg_N = 1'b1;
    repeat (2) cyc();

    // Round robin: all three pending, twice.
    set_msg(0, 8'h90, 8'h3C, 8'h64, 3);
    set_msg(1, 8'hB0, 8'h07, 8'h7F, 2);
    set_msg(2, 8'hC0, 8'h05, 8'h00, 1);
    uart_low = 20;
    a0 = ack_log.size();
    start_batch(3'b111); wait_batch(3'b111, 3000);
    start_batch(3'b111); wait_batch(3'b111, 3000);
    want = '{0, 1, 2, 0, 1, 2};
    check_log("rr_grant_order", 1'b1, a0);

    // Single three-byte message with a slow UART.
    uart_low = 800;
    n0 = sent_log.size(); a0 = ack_log.size();
    start_batch(3'b001); wait_batch(3'b001, 6000);
    want = '{'h90, 'h3C, 'h64};
    check_log("note_on_bytes", 1'b0, n0);
    want = '{0};
    check_log("note_on_ack", 1'b1, a0);

    // Zero-length message on requester 1.
    uart_low = 30;
    set_msg(1, 8'hB0, 8'h00, 8'h00, 0);
    repeat (2) cyc();
    n0 = sent_log.size(); busy_cyc = 0;
    start_batch(3'b010); wait_batch(3'b010, 100);
    repeat (3) cyc();
    chk_range("len0_busy_cycles", busy_cyc, 1, 3);
    chk("len0_strobes", 32'(sent_log.size() - n0), 32'd0);

    // UART ready stuck high after the strobe: handshake timeout.
    set_msg(2, 8'hE0, 8'h40, 8'h00, 3);
    uart_stuck = 1'b1; m_stuck = 1'b1;
    start_batch(3'b100); wait_batch(3'b100, TO + 200);
    m_stuck = 1'b0; uart_stuck = 1'b0;
    chk_range("timeout_latency", ack_cyc - strobe_cyc, TO, TO + 2);
    chk("tx_timeout_set", 32'(tx_timeout), 32'd1);
    repeat (5) cyc();
    chk("tx_timeout_sticky", 32'(tx_timeout), 32'd1);
    clr_err = 1'b1; cyc(); clr_err = 1'b0; cyc();
    chk("tx_timeout_cleared", 32'(tx_timeout), 32'd0);

    // Running-status sequence on requester 0.
    uart_low = 30;
    n0 = sent_log.size();
    set_msg(0, 8'h90, 8'h3C, 8'h64, 3); start_batch(3'b001); wait_batch(3'b001, 2000);
    set_msg(0, 8'h90, 8'h40, 8'h50, 3); start_batch(3'b001); wait_batch(3'b001, 2000);
    set_msg(0, 8'hF8, 8'h00, 8'h00, 1); start_batch(3'b001); wait_batch(3'b001, 2000);
    set_msg(0, 8'h90, 8'h43, 8'h20, 3); start_batch(3'b001); wait_batch(3'b001, 2000);
`ifdef RUNNING_STATUS_EN
    want = '{'h90, 'h3C, 'h64, 'h40, 'h50, 'hF8, 'h43, 'h20};
`else
    want = '{'h90, 'h3C, 'h64, 'h90, 'h40, 'h50, 'hF8, 'h90, 'h43, 'h20};
`endif
    check_log("running_status_bytes", 1'b0, n0);

    // Reset during WAIT_HIGH of the second byte, then full resend.
    set_msg(0, 8'hA0, 8'h3C, 8'h64, 3);
    uart_low = 200;
    n0 = sent_log.size();
    start_batch(3'b001);
    k = 0;
    while (sent_log.size() < n0 + 2 && k < 3000) begin
      cyc();
      k++;
    end
    chk("reached_second_byte", 32'(sent_log.size() - n0), 32'd2);
    repeat (60) cyc();
    #2 reset_reg_N = 1'b0;
    #1 reset_checks("mid_msg_reset");
    exp_q.delete();
    m_ptr = 0; m_rs = 0;
    a0 = ack_log.size();
    repeat (4) cyc();
    chk("no_ack_during_reset", 32'(ack_log.size() - a0), 32'd0);
    reset_reg_N = 1'b1;
    n0 = sent_log.size();
    model_batch(3'b001);
    wait_batch(3'b001, 3000);
    want = '{'hA0, 'h3C, 'h64};
    check_log("resend_after_reset", 1'b0, n0);

    repeat (3) cyc();
    chk("expected_events_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
